am25ls153_arb: RTL and testbench
================================

Name: am25ls153_arb

Overview:
- Round-robin arbiter and sequencer for one am25ls153 4-line-to-1 selector.
- Four requesters share the selector output `y`; the block drives the selector's `sel[1:0]` and active-low strobe `g`.
- It grants one requester at a time, with a programmable burst limit so no requester starves the others.
- Sits between the requesting sources (on the `c[3:0]` inputs) and the downstream consumer of `y`.

Parameters:
- MAXBURST, 4: max consecutive granted cycles per owner before forced rotation. Legal range 1..15.
- CW, 4: burst counter width. Must satisfy 2**CW > MAXBURST.

Ports:
- clk    in   1  system clock, rising edge.
- rst    in   1  synchronous, active-high reset.
- req    in   4  request per selector input; `req[i]` asks for line `c[i]`.
- last   in   4  `last[i]`: the owner's current cycle is its final transfer; only meaningful while `gnt[i]` = 1.
- sel    out  2  selector address to am25ls153 `sel`.
- g      out  1  selector strobe to am25ls153 `g`, active low; 1 = `y` forced low/idle.
- gnt    out  4  one-hot grant; all zero when idle.
- busy   out  1  1 while any grant is active (equal to `~g`).

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.

Reset (synchronous, `rst` sampled high at the edge):
- `sel`=00, `g`=1, `gnt`=0000, `busy`=0.
- Internal: state=IDLE, priority pointer `ptr`=0, burst counter `cnt`=0.
- Reset mid-grant takes effect at that edge with the same values. No partial transfer is completed.

Round-robin pick:
- Winner = first `i` with `req[i]`=1, scanning `ptr`, `ptr+1`, ... modulo 4.

States:
- IDLE:
  - If any `req` is high at edge N, after edge N: state=GRANT, `sel`=winner, `g`=0, `gnt`=onehot(winner), `cnt`=1.
  - Request-to-grant latency is 1 cycle.
  - Otherwise hold idle outputs. `sel` keeps its last value; it is don't-care while `g`=1.
- GRANT (owner `o` = `sel`). Evaluated every edge; release if any of:
  - (a) `req[o]`=0;
  - (b) `last[o]`=1;
  - (c) `cnt`==MAXBURST.
- No release: `cnt`++, outputs held.
- On release:
  - `ptr` = (o+1) mod 4, then the pick runs with the updated `ptr` in the same edge.
  - The released owner is eligible last, and only if `req[o]` is still 1. Under cause (a) it is excluded.
  - Under cause (b), `req[o]` is ignored for this edge's pick, so the owner is not re-granted on its last cycle.
  - Winner exists: direct handoff with no idle cycle. `sel`=winner, `gnt`=onehot(winner), `g` stays 0, `cnt`=1.
  - No winner: state=IDLE, `g`=1, `gnt`=0000.

Boundary rules:
- `last[o]` and `cnt`==MAXBURST in the same cycle: a single release.
- `last` bits of non-owners are ignored.
- Sole requester hitting MAXBURST: `gnt` stays asserted, `cnt` reloads to 1, `ptr` advances. Visible only as a counter reload.
- MAXBURST=1: a strict one-cycle rotation among active requesters.
- `req` changes for non-owners mid-grant have no effect until release.
- X on `req`/`last` is not legal input. After reset, outputs never carry X.

Decomposition:
- Shared package `am25ls153_pkg`:
  - state encoding constants IDLE=1'b0, GRANT=1'b1;
  - localparam NREQ=4;
  - function onehot4(sel) → 4-bit.
- One sub-module: `am25ls153_rrpick`, combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`.
  - Outputs: `valid`, `idx[1:0]`.
  - `mask` excludes the released owner for the causes in Behaviour.
- The top module instantiates the `am25ls153` model in its own test bench only, not inside the arbiter.

Test Plan:
- 1. Reset with `req`=1111, then deassert `rst` → first edge after: `sel`=00, `g`=0, `gnt`=0001, `busy`=1.
- 2. `req`=1111 held, no `last`, MAXBURST=4:
  - `gnt` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…;
  - `g` stays 0 throughout (no gap);
  - via the am25ls153 model, `y` tracks `c[sel]`.
- 3. `req`=0100 only, `last[2]` pulsed at cycle 2 of the grant → `gnt`=0100 for exactly 2 cycles, then `g`=1, `gnt`=0000 at the next edge; `ptr`=3.
- 4. `req`=0001 only for 10 cycles, MAXBURST=4 → `gnt`=0001 continuously, `g`=0 throughout; the counter reloads every 4 cycles.
- 5. Owner 1 drops `req[1]` while `req[3]` is high → next edge `sel`=11, `gnt`=1000, no `g`=1 cycle.
- 6. Assert `rst` during cycle 2 of a grant to `sel`=10 → next edge `sel`=00, `g`=1, `gnt`=0000. With `req`=0100 still high after release, `gnt`=0100 one cycle after `rst` falls.

Source files
------------

// File: rtl/am25ls153_pkg.sv
// Shared types and helpers for the am25ls153 round-robin arbiter.
// State encoding, requester count and the one-hot decode used by the arbiter and the picker.
package am25ls153_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/am25ls153_arb_if.sv
// Requester/selector bundle between the sources, the arbiter and the am25ls153 control pins.
// The master side is the arbiter and the slave side is the requesters.
interface am25ls153_arb_if;
  logic [3:0] req;
  logic [3:0] last;
  logic [1:0] sel;
  logic       g;
  logic [3:0] gnt;
  logic       busy;

  modport master (
    input  req, last,
    output sel, g, gnt, busy
  );

  modport slave (
    output req, last,
    input  sel, g, gnt, busy
  );
endinterface

// File: rtl/am25ls153_rrpick.sv
// Combinational round-robin picker: the first unmasked request found scanning from ptr upward, modulo 4.
module am25ls153_rrpick
  import am25ls153_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  input  logic [NREQ-1:0] mask_i,
  output logic            valid_o,
  output logic [1:0]      idx_o
);

  logic [NREQ-1:0] eligible;
  logic [1:0]      cand;
  logic            found;

  assign eligible = req_i & ~mask_i;
  assign valid_o  = |eligible;

  always_comb begin
    idx_o = ptr_i;
    found = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_i + 2'(k);
      if (!found && eligible[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/am25ls153_arb.sv
// Round-robin arbiter driving sel/g of one am25ls153, with a burst limit forcing rotation.
// Every output is registered.
module am25ls153_arb
  import am25ls153_pkg::*;
#(
  parameter int MAXBURST = 4,
  parameter int CW       = 4
) (
  input logic           clk,
  input logic           rst,
  am25ls153_arb_if.master bus
);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            g_q, g_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic [1:0]      owner;
  logic            ownerLast;
  logic            burstDone;
  logic            releaseNow;
  logic [1:0]      pickPtr;
  logic [NREQ-1:0] pickMask;
  logic            pickValid;
  logic [1:0]      pickIdx;

  assign owner      = sel_q;
  assign ownerLast  = bus.last[owner];
  assign burstDone  = (cnt_q == CW'(MAXBURST));
  assign releaseNow = (state_q == GRANT) && (!bus.req[owner] || ownerLast || burstDone);

  // On release the owner lands last in the scan; on its final transfer it is masked out entirely.
  assign pickPtr  = (state_q == GRANT) ? owner + 2'd1 : ptr_q;
  assign pickMask = ((state_q == GRANT) && ownerLast) ? onehot4(owner) : '0;

  am25ls153_rrpick u_pick (
    .req_i   (bus.req),
    .ptr_i   (pickPtr),
    .mask_i  (pickMask),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      g_q     <= 1'b1;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = GRANT;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (releaseNow) begin
          ptr_d = owner + 2'd1;
          if (pickValid) begin
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    g_d   = g_q;
    gnt_d = gnt_q;
    if (((state_q == IDLE) || releaseNow) && pickValid) begin
      sel_d = pickIdx;
      g_d   = 1'b0;
      gnt_d = onehot4(pickIdx);
    end else if (releaseNow || (state_q == IDLE)) begin
      g_d   = 1'b1;
      gnt_d = '0;
    end
    busy_d = ~g_d;
  end

  assign bus.sel  = sel_q;
  assign bus.g    = g_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_am25ls153_arb.sv
// Directed bench for am25ls153_arb with a behavioural am25ls153 selector on the output side.
module tb_am25ls153_arb;

  logic       clk;
  logic       rst;
  logic [3:0] cData;
  logic       y;
  int         total;
  int         bad;

  am25ls153_arb_if bus ();

  am25ls153_arb #(.MAXBURST(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // am25ls153 model: y is forced low while the strobe is high.
  assign y = bus.g ? 1'b0 : cData[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] ls);
    rst      = r;
    bus.req  = rq;
    bus.last = ls;
    cData    = 4'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " g"},    32'(bus.g),    32'd1);
    checkOutput({tag, " gnt"},  32'(bus.gnt),  32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic checkGrant(input string tag, input int idx);
    logic [3:0] expGnt;
    expGnt = 4'b0001 << idx;
    checkOutput({tag, " sel"},  32'(bus.sel),  32'(idx));
    checkOutput({tag, " g"},    32'(bus.g),    32'd0);
    checkOutput({tag, " gnt"},  32'(bus.gnt),  32'(expGnt));
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, " y"},    32'(y),        32'(cData[idx]));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    cData    = '0;

    // Reset holds idle even with every line requesting.
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    checkIdle("reset");
    checkOutput("reset sel", 32'(bus.sel), 32'd0);

    // Full load rotates in bursts of four with no idle gap.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000);
      checkGrant($sformatf("rot%0d", k), (k / 4) % 4);
    end

    // Sole requester ends on last; next scan must start at 3.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    checkGrant("last c1", 2);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    checkGrant("last c2", 2);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    checkIdle("last rel");
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkGrant("ptr3", 3);

    // Sole requester keeps the grant across burst reloads.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 4'b0001, 4'b0000);
      checkGrant($sformatf("sole%0d", k), 0);
    end

    // Owner drops its request; handoff to 3 without a gap.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    checkGrant("drop c1", 1);
    applyStimulus(1'b0, 4'b1010, 4'b0000);
    checkGrant("drop c2", 1);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    checkGrant("drop hand", 3);

    // last bits of non-owners are ignored.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkGrant("nolast c1", 0);
    applyStimulus(1'b0, 4'b0011, 4'b0010);
    checkGrant("nolast c2", 0);
    applyStimulus(1'b0, 4'b0011, 4'b1110);
    checkGrant("nolast c3", 0);

    // Reset mid-grant, then regrant one cycle after reset falls.
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    checkGrant("rstmid c1", 2);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    checkGrant("rstmid c2", 2);
    applyStimulus(1'b1, 4'b0100, 4'b0000);
    checkIdle("rstmid rst");
    checkOutput("rstmid sel", 32'(bus.sel), 32'd0);
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    checkGrant("rstmid regrant", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
